// File: rtl/alu_mc_pkg.sv
// Shared funct codes and FSM state encoding for the multi-cycle ALU.
package alu_mc_pkg;

  localparam logic [5:0] FN_ADD   = 6'b001001;
  localparam logic [5:0] FN_SUB   = 6'b001010;
  localparam logic [5:0] FN_SLL   = 6'b100001;
  localparam logic [5:0] FN_SRL   = 6'b100010;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative engine: shift-add multiply, and restoring divide when ALU_MC_DIVU_EN is defined.
// One bit per cycle for WIDTH cycles; o_lo/o_hi carry the value of the step in progress.
module alu_mc_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
`ifdef ALU_MC_DIVU_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic             r_busy;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // Multiply: {hi,lo} starts as {0,multiplier}; add multiplicand into hi, then shift right.
  assign w_sum = {1'b0, r_hi} + {1'b0, r_b & {WIDTH{r_lo[0]}}};

`ifdef ALU_MC_DIVU_EN
  logic           r_div;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
  assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};

  always_comb begin
    w_hi_nxt = w_sum[WIDTH:1];
    w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    if (r_div) begin
      if (w_diff[WIDTH]) begin
        w_hi_nxt = w_rem_sh[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end else begin
        w_hi_nxt = w_diff[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end
    end
  end
`else
  assign w_hi_nxt = w_sum[WIDTH:1];
  assign w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
`ifdef ALU_MC_DIVU_EN
      r_div  <= 1'b0;
`endif
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_b    <= i_b;
      r_hi   <= '0;
      r_lo   <= i_a;
`ifdef ALU_MC_DIVU_EN
      r_div  <= i_div;
`endif
    end else if (r_busy) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + SHW'(1);
      if (r_cnt == LAST) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == LAST);
  assign o_lo   = w_lo_nxt;
  assign o_hi   = w_hi_nxt;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; DIVU is built in when ALU_MC_DIVU_EN is defined.
// Handshake: a transfer happens on a rising edge where valid && ready; in_ready only in IDLE, out_valid only in DONE.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [SHW-1:0]   shamt,
  input  logic [5:0]       funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             illegal,
  output state_t           o_dbg_state
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_start;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ill;
  logic             w_iter_busy;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_lo;
  logic [WIDTH-1:0] w_iter_hi;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_illegal;
`ifdef ALU_MC_DIVU_EN
  logic             w_div;
`endif

  always_comb begin
    w_alu_res = '0;
    w_alu_ill = 1'b0;
    case (funct)
      FN_ADD:  w_alu_res = in1 + in2;
      FN_SUB:  w_alu_res = in1 - in2;
      FN_SLL:  w_alu_res = in1 << shamt;
      FN_SRL:  w_alu_res = in1 >> shamt;
      FN_OR:   w_alu_res = in1 | in2;
      FN_AND:  w_alu_res = in1 & in2;
      FN_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      default: w_alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
`ifdef ALU_MC_DIVU_EN
    w_div       = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (funct == FN_MULTU) begin
            w_start     = 1'b1;
            w_state_nxt = MUL;
`ifdef ALU_MC_DIVU_EN
          end else if (funct == FN_DIVU) begin
            w_start     = 1'b1;
            w_div       = 1'b1;
            w_state_nxt = DIV;
`endif
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      // An idle engine here would mean a lost operation; fall back to IDLE rather than hang.
      MUL: begin
        if (w_iter_done)       w_state_nxt = DONE;
        else if (!w_iter_busy) w_state_nxt = IDLE;
      end
`ifdef ALU_MC_DIVU_EN
      DIV: begin
        if (w_iter_done)       w_state_nxt = DONE;
        else if (!w_iter_busy) w_state_nxt = IDLE;
      end
`endif
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Output registers only change when a new result lands, so they hold through DONE and beyond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_illegal   <= 1'b0;
    end else if (r_state == IDLE && in_valid && !w_start) begin
      r_result    <= w_alu_res;
      r_result_hi <= '0;
      r_illegal   <= w_alu_ill;
    end else if (r_state != IDLE && r_state != DONE && w_iter_done) begin
      r_result    <= w_iter_lo;
      r_result_hi <= w_iter_hi;
      r_illegal   <= 1'b0;
    end
  end

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
`ifdef ALU_MC_DIVU_EN
    .i_div   (w_div),
`endif
    .i_a     (in1),
    .i_b     (in2),
    .o_busy  (w_iter_busy),
    .o_done  (w_iter_done),
    .o_lo    (w_iter_lo),
    .o_hi    (w_iter_hi)
  );

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign result      = r_result;
  assign result_hi   = r_result_hi;
  assign illegal     = r_illegal;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32); honours ALU_MC_DIVU_EN for the DIVU cases.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [4:0]   shamt = '0;
  logic [5:0]   funct = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         illegal;
  state_t       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W:0] exp_q[$];
  logic [2*W:0] exp_v;

  alu_mc #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .shamt       (shamt),
    .funct       (funct),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .illegal     (illegal),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: {illegal, hi, lo}
  function automatic logic [2*W:0] model(input logic [5:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [4:0] sh);
    logic [2*W-1:0] p;
    case (f)
      6'b001001: return {1'b0, 32'h0, a + b};
      6'b001010: return {1'b0, 32'h0, a - b};
      6'b100001: return {1'b0, 32'h0, a << sh};
      6'b100010: return {1'b0, 32'h0, a >> sh};
      6'b100101: return {1'b0, 32'h0, a | b};
      6'b100100: return {1'b0, 32'h0, a & b};
      6'b101010: return {1'b0, 32'h0, 31'h0, ($signed(a) < $signed(b))};
      6'b011001: begin
        p = {32'h0, a} * {32'h0, b};
        return {1'b0, p};
      end
`ifdef ALU_MC_DIVU_EN
      6'b011011: begin
        if (b == 0) return {1'b0, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
`endif
      default: return {1'b1, 64'h0};
    endcase
  endfunction

  function automatic int lat_of(input logic [5:0] f);
`ifdef ALU_MC_DIVU_EN
    if (f == 6'b011011) return W + 1;
`endif
    if (f == 6'b011001) return W + 1;
    return 1;
  endfunction

  // Driver: called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] sh);
    int n = 0;
    in_valid = 1'b1;
    funct = f;
    in1 = a;
    in2 = b;
    shamt = sh;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    exp_q.push_back(model(f, a, b, sh));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = $urandom;
    in2 = $urandom;
    funct = 6'($urandom_range(0, 63));
    shamt = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_out(input int exp_lat);
    int lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
  endtask

  task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh);
    out_ready = 1'b1;
    send(f, a, b, sh);
    wait_out(lat_of(f));
    @(posedge clk); #1;
    check("idle_after_hs", {out_valid, in_ready}, 2'b01);
  endtask

  // Scoreboard: compare on each output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        exp_v = exp_q.pop_front();
        check("sb_result", {illegal, result_hi, result}, exp_v);
      end
    end
  end

  logic [5:0] fn_tab[8];
  int         spur;

  initial begin
    fn_tab = '{6'b001001, 6'b001010, 6'b100001, 6'b100010,
               6'b100101, 6'b100100, 6'b101010, 6'b011001};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_result_hi", result_hi, 0);
    check("rst_illegal", illegal, 0);

    run_op(6'b001001, 32'hFFFF_FFFF, 32'h1, 5'd0);
    run_op(6'b101010, 32'h8000_0000, 32'h1, 5'd0);
    run_op(6'b100010, 32'h8000_0000, 32'h0, 5'd31);
    run_op(6'b100001, 32'h1, 32'h0, 5'd4);
    check("hold_after_hs", result, 32'h10);
    run_op(6'b100001, 32'hDEAD_BEEF, 32'h0, 5'd0);
    run_op(6'b100010, 32'hDEAD_BEEF, 32'h0, 5'd0);
    run_op(6'b001010, 32'h5, 32'h7, 5'd0);
    run_op(6'b100101, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0);
    run_op(6'b100100, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
    run_op(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    check("mul_hi", result_hi, 32'hFFFF_FFFE);
    run_op(6'b011001, 32'h0, 32'h1234_5678, 5'd0);

    // Backpressure with a competing request held on in_valid
    out_ready = 1'b0;
    send(6'b001001, 32'd3, 32'd4, 5'd0);
    wait_out(1);
    in_valid = 1'b1;
    funct = 6'b001001;
    in1 = 32'd10;
    in2 = 32'd10;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {out_valid, in_ready, illegal, result_hi, result}, {1'b1, 1'b0, 1'b0, 32'h0, 32'd7});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_back", in_ready, 1);
    run_op(6'b001001, 32'd10, 32'd10, 5'd0);

    // Reset in the middle of a multiply
    out_ready = 1'b1;
    send(6'b011001, 32'h1234, 32'h5678, 5'd0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1 check("rst_mid_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("rst_mid_state", {out_valid, in_ready}, 2'b01);
    check("rst_mid_result", {illegal, result_hi, result}, 65'h0);
    spur = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) spur++;
    end
    check("no_spurious_valid", spur, 0);

    run_op(6'h3F, 32'h1111, 32'h2222, 5'd3);
    check("illegal_flag", illegal, 1);
`ifdef ALU_MC_DIVU_EN
    run_op(6'b011011, 32'd100, 32'd7, 5'd0);
    check("div_rem", result_hi, 32'd2);
    run_op(6'b011011, 32'd5, 32'd0, 5'd0);
    check("div0_q", result, 32'hFFFF_FFFF);
`else
    run_op(6'b011011, 32'd100, 32'd7, 5'd0);
    check("divu_illegal", illegal, 1);
`endif

    // Random traffic with random output stalls
    for (int k = 0; k < 24; k++) begin
      logic [5:0] f;
      f = fn_tab[$urandom_range(0, 7)];
      out_ready = 1'b0;
      send(f, $urandom, $urandom, 5'($urandom_range(0, 31)));
      wait_out(lat_of(f));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
